// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD power-up / pixel sequencer:
// init-table entry format, entry kinds and the sequencer state encoding.
package lcd_pkg;

  localparam int ENTRY_W = 10;

  localparam logic [1:0] KIND_CMD   = 2'd0;
  localparam logic [1:0] KIND_DATA  = 2'd1;
  localparam logic [1:0] KIND_DELAY = 2'd2;
  localparam logic [1:0] KIND_END   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LO,
    S_RST_HI,
    S_INIT,
    S_DRAIN,
    S_DELAY,
    S_STREAM
  } state_t;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [1:0] kind, input logic [7:0] b);
    return {kind, b};
  endfunction

  function automatic logic is_word(input logic [1:0] kind);
    return (kind == KIND_CMD) || (kind == KIND_DATA);
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel init table: combinational address -> {kind, byte} entry.
// Slots past the last programmed entry read back as END.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [AW-1:0]      addr,
  output logic [ENTRY_W-1:0] entry
);

  // Table lookup; every unlisted address terminates the sequence
  always_comb begin
    entry = mk_entry(KIND_END, 8'h00);
    case (int'(addr))
      0:       entry = mk_entry(KIND_CMD,   8'h11);
      1:       entry = mk_entry(KIND_DELAY, 8'h03);
      2:       entry = mk_entry(KIND_CMD,   8'h29);
      3:       entry = mk_entry(KIND_DATA,  8'h00);
      default: entry = mk_entry(KIND_END,   8'h00);
    endcase
  end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// LCD sequencer in front of the byte serializer: panel reset pulse, init
// table playback with delays, then pixel streaming. Side-band pins are
// forwarded on the accept cycle so they line up with the first serial bit.
// Optional feature macro: LCD_SEQ_FRAME_CNT_EN adds the frame_cnt output.
module lcd_seq_ctrl
  import lcd_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int INIT_LEN   = 16,
  parameter int RST_CYCLES = 1000,
  parameter int DELAY_UNIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  init_done,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [WORD_WIDTH-1:0] pix_data,
  input  logic                  pix_last,
  input  logic                  ser_ready,
  output logic                  ser_valid,
  output logic [WORD_WIDTH-1:0] ser_data,
  output logic                  lcd_rst_n,
  output logic                  lcd_cs_n,
  output logic                  lcd_dc
`ifdef LCD_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int AW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int PW = $clog2(INIT_LEN + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int DW = $clog2(255 * DELAY_UNIT + 1);
  localparam int CW = (RW > DW) ? RW : DW;
  localparam logic [CW-1:0] RST_LOAD = CW'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);

  state_t                state, state_n, ret_q, ret_n;
  logic [CW-1:0]         cnt, cnt_n, delay_load;
  logic [PW-1:0]         ptr, ptr_n, ptr_inc;
  logic [ENTRY_W-1:0]    rom_entry;
  logic [1:0]            cur_kind;
  logic [7:0]            cur_byte;
  logic                  table_end;
  logic                  accept, word_dc, drain_exit;
  logic                  active_q, dc_q, done_q;

  lcd_init_rom #(.AW(AW)) u_rom (
    .addr  (ptr[AW-1:0]),
    .entry (rom_entry)
  );

  assign table_end  = (ptr >= PW'(INIT_LEN));
  assign cur_kind   = table_end ? KIND_END : rom_entry[ENTRY_W-1 -: 2];
  assign cur_byte   = rom_entry[7:0];
  assign ptr_inc    = table_end ? ptr : ptr + 1'b1;
  assign delay_load = (cur_byte == 8'd0) ? '0 : CW'(32'(cur_byte) * 32'(DELAY_UNIT) - 32'd1);

  assign accept    = ser_valid & ser_ready;
  assign busy      = (state != S_IDLE) && (state != S_STREAM);
  assign init_done = done_q;
  assign lcd_dc    = accept ? word_dc : dc_q;
  assign lcd_cs_n  = ~(accept | (active_q & ~drain_exit));

  // Next-state, handshake and counter/pointer decisions for the sequencer
  always_comb begin
    state_n    = state;
    ret_n      = ret_q;
    cnt_n      = cnt;
    ptr_n      = ptr;
    ser_valid  = 1'b0;
    ser_data   = '0;
    pix_ready  = 1'b0;
    word_dc    = 1'b0;
    drain_exit = 1'b0;
    lcd_rst_n  = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RST_LO;
          cnt_n   = RST_LOAD;
        end
      end
      S_RST_LO: begin
        lcd_rst_n = 1'b0;
        if (cnt == '0) begin
          state_n = S_RST_HI;
          cnt_n   = RST_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_RST_HI: begin
        if (cnt == '0) state_n = S_INIT;
        else           cnt_n   = cnt - 1'b1;
      end
      S_INIT: begin
        if (is_word(cur_kind)) begin
          ser_valid = 1'b1;
          ser_data  = WORD_WIDTH'(cur_byte);
          word_dc   = (cur_kind == KIND_DATA);
          if (ser_ready) ptr_n = ptr_inc;
        end else begin
          state_n = S_DRAIN;
          ret_n   = (cur_kind == KIND_DELAY) ? S_DELAY : S_STREAM;
        end
      end
      S_DRAIN: begin
        if (ser_ready) begin
          drain_exit = 1'b1;
          state_n    = ret_q;
          if (ret_q == S_DELAY) cnt_n = delay_load;
        end
      end
      S_DELAY: begin
        if (cnt == '0) begin
          state_n = S_INIT;
          ptr_n   = ptr_inc;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_STREAM: begin
        ser_valid = pix_valid;
        ser_data  = pix_data;
        pix_ready = ser_ready;
        word_dc   = 1'b1;
        if (pix_valid && ser_ready && pix_last) begin
          state_n = S_DRAIN;
          ret_n   = S_STREAM;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, shared counter, table pointer and forwarded side-band registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ret_q    <= S_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      active_q <= 1'b0;
      dc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state <= state_n;
      ret_q <= ret_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      if (accept) begin
        active_q <= 1'b1;
        dc_q     <= word_dc;
      end else if (drain_exit) begin
        active_q <= 1'b0;
      end
      if (state_n == S_STREAM) done_q <= 1'b1;
    end
  end

`ifdef LCD_SEQ_FRAME_CNT_EN
  // Completed-frame counter, bumped on every accepted last pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     frame_cnt <= '0;
    else if (pix_valid && pix_ready && pix_last)  frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl with a small serializer model (ready once per 8
// cycles, first bit on the accept cycle). Table-driven init sequence,
// hand-written frame / async-reset sequences and a randomized stream phase.
// Honours LCD_SEQ_FRAME_CNT_EN for the frame_cnt port.
module tb_lcd_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, init_done;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] pix_data = 8'h00;
  logic       pix_last = 1'b0;
  logic       ser_ready, ser_valid;
  logic [7:0] ser_data;
  logic       lcd_rst_n, lcd_cs_n, lcd_dc;
`ifdef LCD_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lcd_seq_ctrl #(
    .WORD_WIDTH (8),
    .INIT_LEN   (16),
    .RST_CYCLES (4),
    .DELAY_UNIT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .init_done (init_done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .ser_ready (ser_ready),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .lcd_rst_n (lcd_rst_n),
    .lcd_cs_n  (lcd_cs_n),
    .lcd_dc    (lcd_dc)
`ifdef LCD_SEQ_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  // Serializer model: loads on accept, then shifts the remaining 7 bits
  logic [7:0] sh_word;
  logic [3:0] sh_cnt;
  logic       sd;
  assign ser_ready = (sh_cnt == 4'd0);
  assign sd = ser_ready ? (ser_valid ? ser_data[7] : 1'b0) : sh_word[sh_cnt - 4'd1];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_cnt  <= 4'd0;
      sh_word <= 8'h00;
    end else if (ser_valid && ser_ready) begin
      sh_word <= ser_data;
      sh_cnt  <= 4'd7;
    end else if (sh_cnt != 4'd0) begin
      sh_cnt <= sh_cnt - 4'd1;
    end
  end

  typedef struct {
    logic       start;
    logic       pv;
    int         n;
    logic       rst_n;
    logic       cs_n;
    logic       dc;
    logic       sv;
    logic [7:0] sdata;
    logic       busy;
    logic       idone;
    logic       pready;
  } vec_t;

  vec_t init_tab[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive inputs on the falling edge and settle a little before sampling
  task automatic applyStimulus(input logic s, input logic pv, input logic [7:0] pd, input logic pl);
    @(negedge clk);
    start     = s;
    pix_valid = pv;
    pix_data  = pd;
    pix_last  = pl;
    #2;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ser_valid"}, ser_valid, 0);
    checkOutput({tag, " pix_ready"}, pix_ready, 0);
    checkOutput({tag, " busy"},      busy,      0);
    checkOutput({tag, " init_done"}, init_done, 0);
    checkOutput({tag, " lcd_rst_n"}, lcd_rst_n, 1);
    checkOutput({tag, " lcd_cs_n"},  lcd_cs_n,  1);
    checkOutput({tag, " lcd_dc"},    lcd_dc,    0);
`ifdef LCD_SEQ_FRAME_CNT_EN
    checkOutput({tag, " frame_cnt"}, frame_cnt, 0);
`endif
  endtask

  // Cycle 0 is the start pulse; pix_valid held high across the whole init
  task automatic fillTable();
    //                start pv   n  rst_n cs_n dc  sv  sdata  busy idone prdy
    init_tab[0]  = '{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    init_tab[1]  = '{1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[2]  = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[3]  = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[4]  = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    init_tab[5]  = '{1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[6]  = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[7]  = '{1'b0, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[8]  = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1, 1'b0, 1'b0};
    init_tab[9]  = '{1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[10] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[11] = '{1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[12] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    init_tab[13] = '{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
  endtask

  task automatic runInitTable(input string tag);
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < init_tab[i].n; k++) begin
        string nm;
        applyStimulus(init_tab[i].start, init_tab[i].pv, 8'hEE, 1'b0);
        nm = $sformatf("%s[%0d.%0d]", tag, i, k);
        checkOutput({nm, " lcd_rst_n"}, lcd_rst_n, init_tab[i].rst_n);
        checkOutput({nm, " lcd_cs_n"},  lcd_cs_n,  init_tab[i].cs_n);
        checkOutput({nm, " lcd_dc"},    lcd_dc,    init_tab[i].dc);
        checkOutput({nm, " ser_valid"}, ser_valid, init_tab[i].sv);
        if (init_tab[i].sv) checkOutput({nm, " ser_data"}, ser_data, init_tab[i].sdata);
        checkOutput({nm, " busy"},      busy,      init_tab[i].busy);
        checkOutput({nm, " init_done"}, init_done, init_tab[i].idone);
        checkOutput({nm, " pix_ready"}, pix_ready, init_tab[i].pready);
      end
    end
  endtask

  // One frame A5 5A FF: accepts 8 cycles apart, cs_n high from bit 24 on
  task automatic runFrame();
    logic [7:0]  frm [3];
    logic [23:0] bits;
    logic [25:0] acc_mask, cs_mask;
    int idx;
    frm[0] = 8'hA5; frm[1] = 8'h5A; frm[2] = 8'hFF;
    bits = '0; acc_mask = '0; cs_mask = '0; idx = 0;
    for (int k = 0; k < 26; k++) begin
      applyStimulus(1'b0, idx < 3, (idx < 3) ? frm[idx] : 8'h00, idx == 2);
      if (k < 24) bits[23-k] = sd;
      acc_mask[k] = ser_valid & pix_ready;
      cs_mask[k]  = lcd_cs_n;
      if (ser_valid && pix_ready) begin
        checkOutput("frame lcd_dc on accept", lcd_dc, 1);
        idx++;
      end
    end
    checkOutput("frame accept cycles", acc_mask, 26'h0010101);
    checkOutput("frame cs_n profile",  cs_mask,  26'h3000000);
    checkOutput("frame serial bits",   bits,     24'hA55AFF);
`ifdef LCD_SEQ_FRAME_CNT_EN
    checkOutput("frame frame_cnt", frame_cnt, 1);
`endif
  endtask

  // Random stream: a last-pixel accept closes the frame; cs_n stays low for
  // the 7 remaining bits and the sequencer is unavailable for 8 cycles.
  task automatic runRandom(input int cycles);
    logic       pend, cur_l, exp_acc, in_drain, exp_cs, frame_open;
    logic [7:0] cur_d;
    int drain_left, low_left, frames;
    pend = 0; cur_l = 0; cur_d = 0; frame_open = 0;
    drain_left = 0; low_left = 0; frames = 1;
    for (int t = 0; t < cycles; t++) begin
      if (!pend) begin
        pend  = ($urandom_range(0, 99) < 60);
        cur_d = 8'($urandom);
        cur_l = ($urandom_range(0, 3) == 0);
      end
      applyStimulus($urandom_range(0, 19) == 0, pend, cur_d, cur_l);
      in_drain = (drain_left != 0);
      exp_acc  = !in_drain && pend && ser_ready;
      exp_cs   = !(exp_acc || frame_open || (low_left != 0));
      checkOutput("rand accept",    ser_valid & pix_ready, exp_acc);
      checkOutput("rand ser_valid", ser_valid, !in_drain && pend);
      checkOutput("rand pix_ready", pix_ready, !in_drain && ser_ready);
      checkOutput("rand busy",      busy, in_drain);
      checkOutput("rand init_done", init_done, 1);
      checkOutput("rand lcd_rst_n", lcd_rst_n, 1);
      checkOutput("rand lcd_cs_n",  lcd_cs_n, exp_cs);
      checkOutput("rand lcd_dc",    lcd_dc, 1);
      if (exp_acc) checkOutput("rand ser_data", ser_data, cur_d);
`ifdef LCD_SEQ_FRAME_CNT_EN
      checkOutput("rand frame_cnt", frame_cnt, frames);
`endif
      if (low_left != 0)   low_left--;
      if (drain_left != 0) drain_left--;
      if (exp_acc) begin
        pend = 0;
        if (cur_l) begin
          frame_open = 0;
          low_left   = 7;
          drain_left = 8;
          frames++;
        end else begin
          frame_open = 1;
        end
      end
    end
  endtask

  initial begin
    fillTable();
    repeat (3) @(negedge clk);
    #2;
    checkResetValues("in reset");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    checkResetValues("after reset");

    runInitTable("init");
    runFrame();
    runRandom(600);

    // Reset pulse, restart, then pull reset mid-word while in S_INIT
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 28; k++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("midword ser_valid", ser_valid, 1);
    checkOutput("midword busy",      busy, 1);
    #1;
    rst = 1'b0;
    #1;
    checkResetValues("async reset");
    @(negedge clk);
    rst = 1'b1;
    runInitTable("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
